// File: rtl/pipe_pkg.sv
// Shared types and constants for the MEM/WB elastic pipeline stage.
package pipe_pkg;

   localparam int DATA_W            = 64;
   localparam int REG_ID_W          = 5;
   localparam int WB_CTRL_W         = 2;
   localparam int STALL_CNT_W       = 16;
   localparam int WB_REG_WRITE_BIT  = 1;
   localparam int WB_MEM_TO_REG_BIT = 0;

   typedef struct packed {
      logic [DATA_W-1:0]    alu;
      logic [DATA_W-1:0]    mem_data;
      logic [REG_ID_W-1:0]  dest;
      logic [WB_CTRL_W-1:0] wb_ctrl;
   } mem_wb_entry_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } buf_state_t;

endpackage

// File: rtl/mem_wb_pipe_reg_if.sv
// MEM->WB handshake, payload, forwarding and perf signals for the MEM/WB stage.
interface mem_wb_if #(
   parameter int DATA_WIDTH      = 64,
   parameter int REG_ID_WIDTH    = 5,
   parameter int WB_CTRL_WIDTH   = 2,
   parameter int STALL_CNT_WIDTH = 16
);
   logic                       in_valid;
   logic                       in_ready;
   logic [DATA_WIDTH-1:0]      alu_in;
   logic [DATA_WIDTH-1:0]      mem_data_in;
   logic [REG_ID_WIDTH-1:0]    dest_in;
   logic [WB_CTRL_WIDTH-1:0]   wb_ctrl_in;
   logic                       out_valid;
   logic                       out_ready;
   logic [DATA_WIDTH-1:0]      alu_out;
   logic [DATA_WIDTH-1:0]      mem_data_out;
   logic [REG_ID_WIDTH-1:0]    dest_out;
   logic [WB_CTRL_WIDTH-1:0]   wb_ctrl_out;
   logic                       fwd_valid;
   logic [REG_ID_WIDTH-1:0]    fwd_dest;
   logic [DATA_WIDTH-1:0]      fwd_data;
   logic [STALL_CNT_WIDTH-1:0] stall_cnt;

   modport slave (
      input  in_valid, alu_in, mem_data_in, dest_in, wb_ctrl_in, out_ready,
      output in_ready, out_valid, alu_out, mem_data_out, dest_out, wb_ctrl_out,
             fwd_valid, fwd_dest, fwd_data, stall_cnt
   );

   modport master (
      output in_valid, alu_in, mem_data_in, dest_in, wb_ctrl_in, out_ready,
      input  in_ready, out_valid, alu_out, mem_data_out, dest_out, wb_ctrl_out,
             fwd_valid, fwd_dest, fwd_data, stall_cnt
   );

endinterface

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry elastic buffer; in_ready comes from state only, never from out_ready.
//   state | meaning
//   EMPTY | no entry held
//   ONE   | main entry valid, drives outputs
//   TWO   | main and skid valid, upstream stalled
module pipe_skid_buf
   import pipe_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   buf_state_t       state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             accept;
   logic             xfer;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      accept  = in_valid & in_ready;
      xfer    = out_valid & out_ready;
      // Flush only drops valid bits; payload stays as stale data.
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_d = ONE;
                  main_d  = in_data;
               end
            end
            ONE: begin
               if (accept && xfer) begin
                  main_d = in_data;
               end else if (xfer) begin
                  state_d = EMPTY;
               end else if (accept) begin
                  state_d = TWO;
                  skid_d  = in_data;
               end
            end
            TWO: begin
               if (xfer) begin
                  state_d = ONE;
                  main_d  = skid_q;
                  skid_d  = '0;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_comb begin
      in_ready  = (state_q != TWO);
      out_valid = (state_q != EMPTY);
      out_data  = main_q;
   end

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// Elastic MEM/WB stage: skid buffer plus x0 write suppression, WB forwarding and stall counter.
module mem_wb_pipe_reg
   import pipe_pkg::*;
#(
   parameter int DATA_WIDTH      = DATA_W,
   parameter int REG_ID_WIDTH    = REG_ID_W,
   parameter int WB_CTRL_WIDTH   = WB_CTRL_W,
   parameter int STALL_CNT_WIDTH = STALL_CNT_W
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   flush,
   mem_wb_if.slave bus
);

   localparam int PW = 2*DATA_WIDTH + REG_ID_WIDTH + WB_CTRL_WIDTH;

   logic [WB_CTRL_WIDTH-1:0]   wb_ctrl_qual;
   logic [PW-1:0]              in_payload;
   logic [PW-1:0]              out_payload;
   logic                       out_valid;
   logic [WB_CTRL_WIDTH-1:0]   wb_ctrl_o;
   logic [DATA_WIDTH-1:0]      alu_o;
   logic [DATA_WIDTH-1:0]      mem_data_o;
   logic [REG_ID_WIDTH-1:0]    dest_o;
   logic [STALL_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

   // Writes to x0 are dropped at capture so WB and forwarding never see them.
   always_comb begin
      wb_ctrl_qual                   = bus.wb_ctrl_in;
      wb_ctrl_qual[WB_REG_WRITE_BIT] = bus.wb_ctrl_in[WB_REG_WRITE_BIT] & (bus.dest_in != '0);
   end

   assign in_payload = {bus.alu_in, bus.mem_data_in, bus.dest_in, wb_ctrl_qual};

   pipe_skid_buf #(
      .WIDTH(PW)
   ) u_skid_buf (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .in_valid (bus.in_valid),
      .in_ready (bus.in_ready),
      .in_data  (in_payload),
      .out_valid(out_valid),
      .out_ready(bus.out_ready),
      .out_data (out_payload)
   );

   assign {alu_o, mem_data_o, dest_o, wb_ctrl_o} = out_payload;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (out_valid && !bus.out_ready && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.out_valid    = out_valid;
   assign bus.alu_out      = alu_o;
   assign bus.mem_data_out = mem_data_o;
   assign bus.dest_out     = dest_o;
   assign bus.wb_ctrl_out  = wb_ctrl_o;
   assign bus.fwd_valid    = out_valid & wb_ctrl_o[WB_REG_WRITE_BIT];
   assign bus.fwd_dest     = dest_o;
   assign bus.fwd_data     = wb_ctrl_o[WB_MEM_TO_REG_BIT] ? mem_data_o : alu_o;
   assign bus.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Scoreboard bench for mem_wb_pipe_reg: queue model of held entries checked every negedge.
module tb_mem_wb_pipe_reg;
   import pipe_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   logic flush = 1'b0;

   mem_wb_if #(
      .DATA_WIDTH(DATA_W), .REG_ID_WIDTH(REG_ID_W),
      .WB_CTRL_WIDTH(WB_CTRL_W), .STALL_CNT_WIDTH(STALL_CNT_W)
   ) bus ();

   mem_wb_pipe_reg #(
      .DATA_WIDTH(DATA_W), .REG_ID_WIDTH(REG_ID_W),
      .WB_CTRL_WIDTH(WB_CTRL_W), .STALL_CNT_WIDTH(STALL_CNT_W)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .flush(flush),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int            n_chk  = 0;
   int            n_pass = 0;
   mem_wb_entry_t sb_q[$];
   mem_wb_entry_t fr;
   mem_wb_entry_t nx;
   logic [15:0]   exp_stall = '0;
   logic          acc;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
   endtask

   task automatic push(input logic v, input logic [63:0] a, input logic [63:0] m,
                       input logic [4:0] d, input logic [1:0] c);
      bus.in_valid    = v;
      bus.alu_in      = a;
      bus.mem_data_in = m;
      bus.dest_in     = d;
      bus.wb_ctrl_in  = c;
      @(posedge clk);
      #1;
   endtask

   always @(posedge reset) begin
      sb_q.delete();
      exp_stall = '0;
   end

   always @(negedge clk) begin
      if (!reset) begin
         check_val("out_valid", bus.out_valid, sb_q.size() != 0);
         check_val("in_ready", bus.in_ready, sb_q.size() < 2);
         check_val("stall_cnt", bus.stall_cnt, exp_stall);
         if (sb_q.size() != 0) begin
            fr = sb_q[0];
            check_val("alu_out", bus.alu_out, fr.alu);
            check_val("mem_data_out", bus.mem_data_out, fr.mem_data);
            check_val("dest_out", bus.dest_out, fr.dest);
            check_val("wb_ctrl_out", bus.wb_ctrl_out, fr.wb_ctrl);
            check_val("fwd_valid", bus.fwd_valid, fr.wb_ctrl[1]);
            check_val("fwd_dest", bus.fwd_dest, fr.dest);
            check_val("fwd_data", bus.fwd_data, fr.wb_ctrl[0] ? fr.mem_data : fr.alu);
         end else begin
            check_val("fwd_valid_idle", bus.fwd_valid, 1'b0);
         end
         if (sb_q.size() != 0 && !bus.out_ready && exp_stall != 16'hFFFF) exp_stall++;
         acc = bus.in_valid && (sb_q.size() < 2);
         if (flush) begin
            sb_q.delete();
         end else begin
            if (bus.out_ready && sb_q.size() != 0) void'(sb_q.pop_front());
            if (acc) begin
               nx.alu      = bus.alu_in;
               nx.mem_data = bus.mem_data_in;
               nx.dest     = bus.dest_in;
               nx.wb_ctrl  = {bus.wb_ctrl_in[1] && (bus.dest_in != 5'd0), bus.wb_ctrl_in[0]};
               sb_q.push_back(nx);
            end
         end
      end
   end

   initial begin
      bus.in_valid    = 1'b0;
      bus.alu_in      = '0;
      bus.mem_data_in = '0;
      bus.dest_in     = '0;
      bus.wb_ctrl_in  = '0;
      bus.out_ready   = 1'b0;
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check_val("rst_out_valid", bus.out_valid, 1'b0);
      check_val("rst_in_ready", bus.in_ready, 1'b1);
      check_val("rst_alu_out", bus.alu_out, 64'd0);
      check_val("rst_stall", bus.stall_cnt, 16'd0);

      // streaming
      bus.out_ready = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         push(1'b1, 64'(i), ~64'(i), 5'(i), 2'b10);
         check_val("stream_alu", bus.alu_out, 64'(i));
         check_val("stream_ready", bus.in_ready, 1'b1);
      end
      push(1'b0, '0, '0, '0, '0);

      // back-pressure
      bus.out_ready = 1'b0;
      push(1'b1, 64'hAA, 64'h1, 5'd1, 2'b10);
      check_val("bp_a_alu", bus.alu_out, 64'hAA);
      check_val("bp_a_ready", bus.in_ready, 1'b1);
      push(1'b1, 64'hBB, 64'h2, 5'd2, 2'b10);
      check_val("bp_b_ready", bus.in_ready, 1'b0);
      check_val("bp_b_alu", bus.alu_out, 64'hAA);
      push(1'b1, 64'hCC, 64'h3, 5'd3, 2'b10);
      check_val("bp_hold_alu", bus.alu_out, 64'hAA);
      push(1'b0, '0, '0, '0, '0);
      push(1'b0, '0, '0, '0, '0);
      bus.out_ready = 1'b1;
      push(1'b0, '0, '0, '0, '0);
      check_val("bp_drain_b", bus.alu_out, 64'hBB);
      push(1'b0, '0, '0, '0, '0);
      check_val("bp_drain_empty", bus.out_valid, 1'b0);

      // x0 suppression
      push(1'b1, 64'h5, 64'h6, 5'd0, 2'b11);
      check_val("x0_ctrl", bus.wb_ctrl_out, 2'b01);
      check_val("x0_fwd_valid", bus.fwd_valid, 1'b0);
      push(1'b1, 64'h5, 64'h6, 5'd7, 2'b11);
      check_val("r7_ctrl", bus.wb_ctrl_out, 2'b11);
      check_val("r7_fwd_valid", bus.fwd_valid, 1'b1);
      check_val("r7_fwd_dest", bus.fwd_dest, 5'd7);

      // forward mux
      push(1'b1, 64'h10, 64'h20, 5'd3, 2'b11);
      check_val("fwd_mem", bus.fwd_data, 64'h20);
      push(1'b1, 64'h10, 64'h20, 5'd3, 2'b10);
      check_val("fwd_alu", bus.fwd_data, 64'h10);
      push(1'b0, '0, '0, '0, '0);

      // flush in TWO with a colliding input
      bus.out_ready = 1'b0;
      push(1'b1, 64'h111, 64'h0, 5'd4, 2'b10);
      push(1'b1, 64'h222, 64'h0, 5'd5, 2'b10);
      flush = 1'b1;
      push(1'b1, 64'h333, 64'h0, 5'd6, 2'b10);
      flush = 1'b0;
      check_val("flush_valid", bus.out_valid, 1'b0);
      check_val("flush_ready", bus.in_ready, 1'b1);
      check_val("flush_stale_alu", bus.alu_out, 64'h111);
      bus.out_ready = 1'b1;
      repeat (3) push(1'b0, '0, '0, '0, '0);
      check_val("flush_no_ghost", bus.out_valid, 1'b0);

      // random traffic
      for (int i = 0; i < 300; i++) begin
         bus.out_ready = 1'($urandom_range(0, 1));
         flush         = ($urandom_range(0, 15) == 0);
         push(1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
              5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
      end
      flush = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) push(1'b0, '0, '0, '0, '0);

      // asynchronous reset with two entries held
      bus.out_ready = 1'b0;
      push(1'b1, 64'hDEAD, 64'hBEEF, 5'd9, 2'b11);
      push(1'b1, 64'hF00D, 64'hCAFE, 5'd10, 2'b11);
      bus.in_valid = 1'b0;
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check_val("amr_out_valid", bus.out_valid, 1'b0);
      check_val("amr_in_ready", bus.in_ready, 1'b1);
      check_val("amr_alu", bus.alu_out, 64'd0);
      check_val("amr_mem", bus.mem_data_out, 64'd0);
      check_val("amr_dest", bus.dest_out, 5'd0);
      check_val("amr_ctrl", bus.wb_ctrl_out, 2'b00);
      check_val("amr_fwd_valid", bus.fwd_valid, 1'b0);
      check_val("amr_stall", bus.stall_cnt, 16'd0);
      @(posedge clk);
      #1 reset = 1'b0;

      // stall counter saturation
      push(1'b1, 64'h77, 64'h0, 5'd1, 2'b10);
      bus.in_valid = 1'b0;
      repeat (65541) @(posedge clk);
      #1;
      check_val("stall_sat", bus.stall_cnt, 16'hFFFF);
      bus.out_ready = 1'b1;
      repeat (2) push(1'b0, '0, '0, '0, '0);
      check_val("stall_sat_hold", bus.stall_cnt, 16'hFFFF);
      check_val("sat_drained", bus.out_valid, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mem_wb_pipe_reg.md
Name: mem_wb_pipe_reg

Overview:
Elastic MEM/WB pipeline stage, the successor of the fixed-width, always-advancing MEM/WB register. It carries the ALU result, load data, destination register and writeback control from MEM to WB. It adds a valid/ready handshake with a 2-entry skid buffer, synchronous flush, and x0 write suppression. It also drives a WB forwarding port and a saturating back-pressure counter for the hazard unit and perf monitors.

Parameters:
DATA_WIDTH, 64, width of ALU result and load data
REG_ID_WIDTH, 5, destination register index width
WB_CTRL_WIDTH, 2, writeback control width; bit 1 = reg_write, bit 0 = mem_to_reg, bits above 1 passed through untouched
STALL_CNT_WIDTH, 16, width of back-pressure cycle counter

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous kill of all held entries
in_valid  in  1  MEM stage presents an entry
in_ready  out  1  stage can accept an entry this cycle
alu_in  in  DATA_WIDTH  ALU result
mem_data_in  in  DATA_WIDTH  load data
dest_in  in  REG_ID_WIDTH  destination register
wb_ctrl_in  in  WB_CTRL_WIDTH  writeback control
out_valid  out  1  WB entry valid
out_ready  in  1  WB stage consumes entry
alu_out  out  DATA_WIDTH  held ALU result
mem_data_out  out  DATA_WIDTH  held load data
dest_out  out  REG_ID_WIDTH  held destination
wb_ctrl_out  out  WB_CTRL_WIDTH  held control (reg_write already x0-qualified)
fwd_valid  out  1  out_valid & wb_ctrl_out[1]
fwd_dest  out  REG_ID_WIDTH  equals dest_out
fwd_data  out  DATA_WIDTH  wb_ctrl_out[0] ? mem_data_out : alu_out
stall_cnt  out  STALL_CNT_WIDTH  cycles with out_valid & !out_ready

Behaviour:
- Reset (async, any time, including mid-transfer): state EMPTY; main and skid entries, all payload outputs and stall_cnt = 0; out_valid = 0, in_ready = 1, fwd_valid = 0.
- Storage: main entry drives the outputs; skid entry is used only under back-pressure. in_ready = !skid_valid, driven from a register, never combinationally from out_ready.
- Accept condition: in_valid & in_ready. Transfer condition: out_valid & out_ready. Latency is 1 cycle from accept to out_valid when the stage is empty.
- Capture: the stored reg_write = wb_ctrl_in[1] & (dest_in != 0). All other fields are stored verbatim.
- FSM (state = valid bits of main/skid):
  - EMPTY: accept -> ONE (load main).
  - ONE, transfer & accept: stay ONE, main replaced. Transfer only -> EMPTY. Accept only -> TWO (load skid). Neither: hold.
  - TWO, in_ready = 0: transfer -> ONE (skid moves to main, skid cleared); else hold.
- Ordering is strictly FIFO; no entry is dropped or duplicated.
- Flush (sync): next state EMPTY. Any in_valid in the same cycle is discarded. Payload registers keep their values; only the valid bits clear. Flush has priority over accept/transfer. Reset has priority over flush.
- When out_valid = 0, the outputs hold stale payload and fwd_valid = 0. Consumers must qualify on valid.
- Forward port: purely combinational from the main entry, no added latency.
- stall_cnt: +1 per cycle with out_valid & !out_ready; saturates at all-ones. Not cleared by flush.
- A held entry (!out_ready) keeps all outputs stable until transfer.

Decomposition:
- Shared package pipe_pkg: WB_REG_WRITE_BIT = 1, WB_MEM_TO_REG_BIT = 0, packed struct mem_wb_entry_t {alu, mem_data, dest, wb_ctrl} sized from package constants matching the defaults, state enum {EMPTY, ONE, TWO}.
- Sub-module pipe_skid_buf: generic 2-entry elastic buffer on a WIDTH-bit payload with flush. mem_wb_pipe_reg wraps it and adds x0 qualification, forwarding and stall_cnt.

Test Plan:
- Reset mid-stream: assert reset async between edges with TWO held -> outputs 0, out_valid = 0, in_ready = 1 immediately, stall_cnt = 0.
- Streaming: out_ready = 1, in_valid each cycle, alu_in = 1,2,3… -> alu_out shows 1,2,3… one cycle later, in_ready stays 1, no gaps.
- Back-pressure: push A = 0xAA, B = 0xBB with out_ready = 0 -> in_ready drops after B, alu_out = 0xAA held, stall_cnt increments each cycle. Raise out_ready -> 0xAA, then 0xBB, then out_valid = 0.
- x0 suppression: dest_in = 0, wb_ctrl_in = 2'b11 -> wb_ctrl_out = 2'b01, fwd_valid = 0. dest_in = 7 -> wb_ctrl_out = 2'b11, fwd_valid = 1, fwd_dest = 7.
- Forward mux: alu_in = 0x10, mem_data_in = 0x20, mem_to_reg = 1 -> fwd_data = 0x20. With mem_to_reg = 0 -> fwd_data = 0x10.
- Flush in TWO with in_valid = 1 -> next cycle out_valid = 0, in_ready = 1, flushed entry never appears. Also drive out_valid = 1, out_ready = 0 for 2^16+5 cycles -> stall_cnt saturates at 0xFFFF.
